program_check_sequencer: RTL and testbench
==========================================

Name: program_check_sequencer

Overview:
- Synthesizable, parametrised self-test sequencer for the single-cycle processor top.
- Replaces bench-side hierarchical pokes with a real sequence: load a program into instruction memory, preload registers, release the core for a fixed cycle budget, stall it, then read back and compare registers.
- Sits beside the processor top and drives the instruction-memory write port, the register-file debug port and the core reset/stall.
- Reports pass/fail and the first mismatch.

Parameters:
- DATA_W, 32, instruction and register width
- IMEM_AW, 8, instruction-memory address width
- REG_AW, 5, register index width
- MAX_ENTRIES, 16, max entries per table (program, init, check)
- RUN_CYCLES, 12, cycles the core runs with reset and stall deasserted
- LEN_W, $clog2(MAX_ENTRIES+1), width of the length inputs

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  begin a sequence; sampled only in IDLE or DONE
- prog_len  in  LEN_W  program words to load
- init_len  in  LEN_W  register preloads
- chk_len  in  LEN_W  register checks
- tbl_sel  out  2  table select: 0 program, 1 init, 2 check
- tbl_idx  out  LEN_W-1  entry index
- tbl_reg  in  REG_AW  register index of the selected entry (ignored for program)
- tbl_data  in  DATA_W  instruction word, init value or expected value; combinational from tbl_sel/tbl_idx
- imem_we  out  1  instruction-memory write enable
- imem_addr  out  IMEM_AW  word address (zero-extended tbl_idx)
- imem_wdata  out  DATA_W  instruction word
- dbg_we  out  1  register-file debug write enable
- dbg_addr  out  REG_AW  debug read/write index
- dbg_wdata  out  DATA_W  debug write data
- dbg_rdata  in  DATA_W  combinational debug read data
- cpu_reset  out  1  core reset, active-high
- cpu_stall  out  1  core freeze
- busy  out  1  sequence in progress
- done  out  1  sequence complete; held until the next accepted start
- pass  out  1  valid while done
- fail_idx  out  LEN_W-1  check index of the first mismatch
- fail_value  out  DATA_W  dbg_rdata observed at the first mismatch

Behaviour:
- Reset: state IDLE.
  - cpu_reset=1.
  - All other outputs 0: busy, done, pass, fail_idx, fail_value, imem_we, dbg_we, cpu_stall, tbl_sel, tbl_idx.
- State sequence: IDLE -> LOAD -> INIT -> RUN -> CHECK -> DONE.
- Start: start in IDLE or DONE latches the three lengths, clears done, pass and the fail fields, sets busy, and moves to LOAD next cycle. start in any other state is ignored.
- LOAD:
  - cpu_reset=1.
  - One word per cycle: imem_we=1, imem_addr=idx, imem_wdata=tbl_data, tbl_sel=0.
  - prog_len cycles, then INIT.
- INIT:
  - cpu_reset=1.
  - One write per cycle: dbg_we=1, dbg_addr=tbl_reg, dbg_wdata=tbl_data.
  - init_len cycles, then RUN.
- RUN:
  - cpu_reset=0, cpu_stall=0.
  - Exactly RUN_CYCLES cycles, counted by an internal down-counter, then CHECK.
- CHECK:
  - cpu_stall=1, cpu_reset=0.
  - One compare per cycle: dbg_addr=tbl_reg; compare dbg_rdata against tbl_data (full-width equality).
  - On the first mismatch, capture fail_idx and fail_value, set pass=0 and go to DONE the next cycle; remaining checks are skipped.
  - After chk_len matching compares, pass=1 and go to DONE.
- DONE:
  - busy=0, done=1.
  - cpu_stall=1, cpu_reset=1.
  - Results are held.
- Zero-length phases are skipped with no cycle spent; chk_len=0 gives pass=1.
- Lengths above MAX_ENTRIES saturate to MAX_ENTRIES.
- The index counter resets to 0 on every phase entry and never wraps within a phase.
- Latency: with start accepted at cycle T, done is first high at cycle T+1+P+I+RUN_CYCLES+C, where P, I and C are the effective lengths and C is truncated at the first mismatch (mismatch at index k gives C=k+1).
- Reset asserted mid-sequence returns to the reset state on the next edge, with no further writes. Partially loaded memory contents are not restored.
- Write enables are never high outside their phase, and never on the cycle reset is high.

Decomposition:
- Shared package (proc_pkg) holds:
  - the state enum: IDLE, LOAD, INIT, RUN, CHECK, DONE
  - the table-select constants: TBL_PROG=0, TBL_INIT=1, TBL_CHECK=2
  - DATA_W and REG_AW defaults shared with the register file and instruction memory.
- One natural sub-module, seq_phase_counter: the loadable index/cycle down-counter with a terminal-count flag. It is instantiated for entry indexing and for the run budget.

Test Plan:
- Add/sub program:
  - Stimulus: prog {0x00A90000, 0x00A00801}, init {r5=15, r9=5}, checks {r0=20, r1=0xFFFFFFFB}.
  - Required response: two imem writes, then two dbg writes, then done at T+1+2+2+12+2 with pass=1.
- Wrong expectation:
  - Stimulus: same run with check r1=0xFFFFFFFA.
  - Required response: pass=0, fail_idx=1, fail_value=0xFFFFFFFB, done one cycle after that compare.
- All lengths 0:
  - Required response: done at T+1+RUN_CYCLES, pass=1, no imem_we or dbg_we pulses.
- Start while busy:
  - Stimulus: pulse start during RUN.
  - Required response: ignored; lengths and timing unchanged.
- Mid-sequence reset:
  - Stimulus: assert reset during INIT, second write.
  - Required response: next cycle state IDLE, cpu_reset=1, dbg_we=0, busy=0, done=0. A new start after reset completes normally.
- Length saturation:
  - Stimulus: prog_len = MAX_ENTRIES+3.
  - Required response: exactly MAX_ENTRIES imem writes at addresses 0..MAX_ENTRIES-1.

Source files
------------

// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : proc_pkg
//  Purpose  : Shared types and constants for the single-cycle processor
//             slice and its self-test sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package proc_pkg;

   // Default widths shared by the register file and instruction memory
   localparam int DATA_W = 32;
   localparam int REG_AW = 5;

   // Sequencer phase encoding
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      INIT  = 3'd2,
      RUN   = 3'd3,
      CHECK = 3'd4,
      DONE  = 3'd5
   } seq_state_t;

   // Table selectors presented to the stimulus tables
   localparam logic [1:0] TBL_PROG  = 2'd0;
   localparam logic [1:0] TBL_INIT  = 2'd1;
   localparam logic [1:0] TBL_CHECK = 2'd2;

endpackage
`default_nettype wire

// File: rtl/seq_phase_counter.sv
`default_nettype none
// ============================================================================
//  Module   : seq_phase_counter
//  Purpose  : Loadable down-counter with terminal-count flag. Stops at zero
//             instead of wrapping.
//  Revision : 1.0  initial release
// ============================================================================
module seq_phase_counter #(
   parameter int WIDTH = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_en,
   output logic [WIDTH-1:0] o_count,
   output logic             o_tc
);

   logic [WIDTH-1:0] r_count;

   // Load has priority over counting; the count saturates at zero
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en && (r_count != '0)) begin
         r_count <= r_count - WIDTH'(1);
      end
   end

   assign o_count = r_count;
   assign o_tc    = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/program_check_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : program_check_sequencer
//  Purpose  : Self-test sequencer: loads a program, preloads registers, runs
//             the core for a fixed budget, then compares registers and
//             reports pass/fail with the first mismatch.
//  Revision : 1.0  initial release
// ============================================================================
module program_check_sequencer
   import proc_pkg::*;
#(
   parameter int DATA_W      = proc_pkg::DATA_W,
   parameter int IMEM_AW     = 8,
   parameter int REG_AW      = proc_pkg::REG_AW,
   parameter int MAX_ENTRIES = 16,
   parameter int RUN_CYCLES  = 12,
   parameter int LEN_W       = $clog2(MAX_ENTRIES + 1)
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic [LEN_W-1:0]   i_prog_len,
   input  logic [LEN_W-1:0]   i_init_len,
   input  logic [LEN_W-1:0]   i_chk_len,
   output logic [1:0]         o_tbl_sel,
   output logic [LEN_W-2:0]   o_tbl_idx,
   input  logic [REG_AW-1:0]  i_tbl_reg,
   input  logic [DATA_W-1:0]  i_tbl_data,
   output logic               o_imem_we,
   output logic [IMEM_AW-1:0] o_imem_addr,
   output logic [DATA_W-1:0]  o_imem_wdata,
   output logic               o_dbg_we,
   output logic [REG_AW-1:0]  o_dbg_addr,
   output logic [DATA_W-1:0]  o_dbg_wdata,
   input  logic [DATA_W-1:0]  i_dbg_rdata,
   output logic               o_cpu_reset,
   output logic               o_cpu_stall,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_pass,
   output logic [LEN_W-2:0]   o_fail_idx,
   output logic [DATA_W-1:0]  o_fail_value
);

   localparam int c_idx_w = LEN_W - 1;
   localparam int c_run_w = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
   localparam int c_cnt_w = (c_idx_w > c_run_w) ? c_idx_w : c_run_w;

   seq_state_t          r_state;
   seq_state_t          w_next;
   logic [LEN_W-1:0]    r_prog_len, r_init_len, r_chk_len;
   logic [LEN_W-1:0]    w_sat_p, w_sat_i, w_sat_c;
   logic [c_cnt_w-1:0]  r_len_m1;
   logic [c_cnt_w-1:0]  w_ld_m1;
   logic [c_cnt_w-1:0]  w_cnt;
   logic [c_idx_w-1:0]  w_idx;
   logic                w_tc, w_cnt_ld, w_cnt_en, w_start, w_mismatch;
   logic                r_pass;
   logic [c_idx_w-1:0]  r_fail_idx;
   logic [DATA_W-1:0]   r_fail_value;

   assign w_sat_p = (i_prog_len > LEN_W'(MAX_ENTRIES)) ? LEN_W'(MAX_ENTRIES) : i_prog_len;
   assign w_sat_i = (i_init_len > LEN_W'(MAX_ENTRIES)) ? LEN_W'(MAX_ENTRIES) : i_init_len;
   assign w_sat_c = (i_chk_len  > LEN_W'(MAX_ENTRIES)) ? LEN_W'(MAX_ENTRIES) : i_chk_len;

   assign w_start    = i_start && ((r_state == IDLE) || (r_state == DONE));
   assign w_mismatch = (r_state == CHECK) && (i_dbg_rdata != i_tbl_data);

   // One counter serves entry indexing and the run budget: the phases never
   // overlap, and it is reloaded on every phase change.
   assign w_cnt_ld = (w_next != r_state);
   assign w_cnt_en = (r_state == LOAD) || (r_state == INIT) ||
                     (r_state == RUN)  || (r_state == CHECK);
   assign w_idx    = c_idx_w'(r_len_m1 - w_cnt);

   seq_phase_counter #(
      .WIDTH (c_cnt_w)
   ) u_phase_cnt (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_load     (w_cnt_ld),
      .i_load_val (w_ld_m1),
      .i_en       (w_cnt_en),
      .o_count    (w_cnt),
      .o_tc       (w_tc)
   );

   // Reload value (length minus one) for the phase being entered
   always_comb begin
      w_ld_m1 = '0;
      case (w_next)
         LOAD:    w_ld_m1 = c_cnt_w'(w_sat_p) - c_cnt_w'(1);
         INIT:    w_ld_m1 = c_cnt_w'(w_start ? w_sat_i : r_init_len) - c_cnt_w'(1);
         RUN:     w_ld_m1 = c_cnt_w'(RUN_CYCLES - 1);
         CHECK:   w_ld_m1 = c_cnt_w'(r_chk_len) - c_cnt_w'(1);
         default: w_ld_m1 = '0;
      endcase
   end

   // State register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; empty phases are skipped without spending a cycle
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE, DONE: begin
            if (i_start) begin
               if (w_sat_p != '0)      w_next = LOAD;
               else if (w_sat_i != '0) w_next = INIT;
               else                    w_next = RUN;
            end
         end
         LOAD:    if (w_tc) w_next = (r_init_len != '0) ? INIT : RUN;
         INIT:    if (w_tc) w_next = RUN;
         RUN:     if (w_tc) w_next = (r_chk_len != '0) ? CHECK : DONE;
         CHECK:   if (w_mismatch || w_tc) w_next = DONE;
         default: w_next = IDLE;
      endcase
   end

   // Latched lengths, index base and result capture
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_prog_len   <= '0;
         r_init_len   <= '0;
         r_chk_len    <= '0;
         r_len_m1     <= '0;
         r_pass       <= 1'b0;
         r_fail_idx   <= '0;
         r_fail_value <= '0;
      end else begin
         if (w_cnt_ld) begin
            r_len_m1 <= w_ld_m1;
         end
         if (w_start) begin
            r_prog_len   <= w_sat_p;
            r_init_len   <= w_sat_i;
            r_chk_len    <= w_sat_c;
            r_pass       <= 1'b0;
            r_fail_idx   <= '0;
            r_fail_value <= '0;
         end else if (r_state == CHECK) begin
            if (w_mismatch) begin
               r_fail_idx   <= w_idx;
               r_fail_value <= i_dbg_rdata;
            end else if (w_tc) begin
               r_pass <= 1'b1;
            end
         end else if ((r_state == RUN) && w_tc && (r_chk_len == '0)) begin
            r_pass <= 1'b1;
         end
      end
   end

   // Phase-decoded outputs; write enables are masked while reset is high
   always_comb begin
      o_tbl_sel    = TBL_PROG;
      o_tbl_idx    = '0;
      o_imem_we    = 1'b0;
      o_imem_addr  = '0;
      o_imem_wdata = '0;
      o_dbg_we     = 1'b0;
      o_dbg_addr   = '0;
      o_dbg_wdata  = '0;
      o_cpu_reset  = 1'b1;
      o_cpu_stall  = 1'b0;
      o_busy       = 1'b0;
      o_done       = 1'b0;
      case (r_state)
         LOAD: begin
            o_busy       = 1'b1;
            o_tbl_sel    = TBL_PROG;
            o_tbl_idx    = w_idx;
            o_imem_we    = !i_reset;
            o_imem_addr  = IMEM_AW'(w_idx);
            o_imem_wdata = i_tbl_data;
         end
         INIT: begin
            o_busy      = 1'b1;
            o_tbl_sel   = TBL_INIT;
            o_tbl_idx   = w_idx;
            o_dbg_we    = !i_reset;
            o_dbg_addr  = i_tbl_reg;
            o_dbg_wdata = i_tbl_data;
         end
         RUN: begin
            o_busy      = 1'b1;
            o_cpu_reset = 1'b0;
         end
         CHECK: begin
            o_busy      = 1'b1;
            o_tbl_sel   = TBL_CHECK;
            o_tbl_idx   = w_idx;
            o_dbg_addr  = i_tbl_reg;
            o_cpu_reset = 1'b0;
            o_cpu_stall = 1'b1;
         end
         DONE: begin
            o_done      = 1'b1;
            o_cpu_stall = 1'b1;
         end
         default: ;
      endcase
   end

   assign o_pass       = r_pass;
   assign o_fail_idx   = r_fail_idx;
   assign o_fail_value = r_fail_value;

endmodule
`default_nettype wire

// File: tb/tb_program_check_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_program_check_sequencer
//  Purpose  : Scoreboard bench for program_check_sequencer with table,
//             register-file and stand-in core models.
//  Revision : 1.0  initial release
// ============================================================================
module tb_program_check_sequencer;
   import proc_pkg::*;

   localparam int MAXE   = 16;
   localparam int RUNC   = 12;
   localparam int LW     = 5;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [LW-1:0] prog_len = '0, init_len = '0, chk_len = '0;
   logic [1:0]    tbl_sel;
   logic [LW-2:0] tbl_idx;
   logic [4:0]    tbl_reg;
   logic [31:0]   tbl_data;
   logic          imem_we;
   logic [7:0]    imem_addr;
   logic [31:0]   imem_wdata;
   logic          dbg_we;
   logic [4:0]    dbg_addr;
   logic [31:0]   dbg_wdata, dbg_rdata;
   logic          cpu_reset, cpu_stall, busy, done, pass;
   logic [LW-2:0] fail_idx;
   logic [31:0]   fail_value;

   logic [31:0] prog [MAXE];
   logic [4:0]  ireg [MAXE];
   logic [31:0] ival [MAXE];
   logic [4:0]  creg [MAXE];
   logic [31:0] cval [MAXE];
   logic [31:0] rf   [32];

   typedef struct {
      int          kind;   // 0 imem write, 1 debug write, 2 done
      logic [31:0] a;
      logic [31:0] d;
      logic        p;
      logic [31:0] fi;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   int   run_cnt  = 0;

   program_check_sequencer #(
      .DATA_W(32), .IMEM_AW(8), .REG_AW(5),
      .MAX_ENTRIES(MAXE), .RUN_CYCLES(RUNC), .LEN_W(LW)
   ) dut (
      .i_clk(clk), .i_reset(reset), .i_start(start),
      .i_prog_len(prog_len), .i_init_len(init_len), .i_chk_len(chk_len),
      .o_tbl_sel(tbl_sel), .o_tbl_idx(tbl_idx),
      .i_tbl_reg(tbl_reg), .i_tbl_data(tbl_data),
      .o_imem_we(imem_we), .o_imem_addr(imem_addr), .o_imem_wdata(imem_wdata),
      .o_dbg_we(dbg_we), .o_dbg_addr(dbg_addr), .o_dbg_wdata(dbg_wdata),
      .i_dbg_rdata(dbg_rdata),
      .o_cpu_reset(cpu_reset), .o_cpu_stall(cpu_stall),
      .o_busy(busy), .o_done(done), .o_pass(pass),
      .o_fail_idx(fail_idx), .o_fail_value(fail_value)
   );

   initial forever #5 clk = ~clk;
   initial forever begin @(posedge clk); cyc++; end

   // Stimulus tables answer combinationally from tbl_sel/tbl_idx
   always_comb begin
      tbl_reg  = '0;
      tbl_data = '0;
      case (tbl_sel)
         2'd0: tbl_data = prog[tbl_idx];
         2'd1: begin tbl_reg = ireg[tbl_idx]; tbl_data = ival[tbl_idx]; end
         2'd2: begin tbl_reg = creg[tbl_idx]; tbl_data = cval[tbl_idx]; end
         default: ;
      endcase
   end

   // Register file with debug port; the stand-in core applies the add/sub
   // program's effect (r0 = r5 + r9, r1 = -r9) whenever it is running.
   assign dbg_rdata = rf[dbg_addr];
   always @(posedge clk) begin
      if (dbg_we) rf[dbg_addr] <= dbg_wdata;
      if (!cpu_reset && !cpu_stall) begin
         rf[0] <= rf[5] + rf[9];
         rf[1] <= 32'd0 - rf[9];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
   endtask

   task automatic unexpected(input string name);
      n_checks++;
      $display("FAIL %s: got an event, required none (scoreboard empty)", name);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents an event
   initial begin
      exp_t e;
      logic prev_done;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) run_cnt = 0;
         else if (!cpu_reset && !cpu_stall) run_cnt++;
         if (imem_we) begin
            if (sb.size() == 0) unexpected("imem_write");
            else begin
               e = sb.pop_front();
               check("imem_kind", 32'(e.kind), 32'd0);
               check("imem_addr", 32'(imem_addr), e.a);
               check("imem_data", imem_wdata, e.d);
            end
         end
         if (dbg_we) begin
            if (sb.size() == 0) unexpected("dbg_write");
            else begin
               e = sb.pop_front();
               check("dbg_kind", 32'(e.kind), 32'd1);
               check("dbg_addr", 32'(dbg_addr), e.a);
               check("dbg_data", dbg_wdata, e.d);
            end
         end
         if (done && !prev_done) begin
            if (sb.size() == 0) unexpected("done");
            else begin
               e = sb.pop_front();
               check("done_kind", 32'(e.kind), 32'd2);
               check("done_cycle", 32'(cyc), 32'(e.cyc));
               check("pass", 32'(pass), 32'(e.p));
               check("fail_idx", 32'(fail_idx), e.fi);
               check("fail_value", fail_value, e.d);
               check("run_cycles", 32'(run_cnt), 32'(RUNC));
               check("done_busy", 32'(busy), 32'd0);
            end
            run_cnt = 0;
         end
         prev_done = done;
      end
   end

   task automatic set_add_sub();
      prog[0] = 32'h00A90000; prog[1] = 32'h00A00801;
      ireg[0] = 5'd5; ival[0] = 32'd15;
      ireg[1] = 5'd9; ival[1] = 32'd5;
      creg[0] = 5'd0; cval[0] = 32'd20;
      creg[1] = 5'd1; cval[1] = 32'hFFFFFFFB;
   endtask

   task automatic push_writes(input int pe, input int ni);
      exp_t e;
      for (int k = 0; k < pe; k++) begin
         e = '{kind: 0, a: 32'(k), d: prog[k], p: 1'b0, fi: 32'd0, cyc: 0};
         sb.push_back(e);
      end
      for (int k = 0; k < ni; k++) begin
         e = '{kind: 1, a: 32'(ireg[k]), d: ival[k], p: 1'b0, fi: 32'd0, cyc: 0};
         sb.push_back(e);
      end
   endtask

   task automatic run_seq(input int p, input int ni, input int nc, input logic ep,
                          input int efi, input logic [31:0] efv, input int ce, input bit poke);
      exp_t e;
      int   pe, t, n;
      pe = (p > MAXE) ? MAXE : p;
      push_writes(pe, ni);
      @(posedge clk); #1;
      prog_len = LW'(p); init_len = LW'(ni); chk_len = LW'(nc);
      start = 1'b1;
      t = cyc;
      e = '{kind: 2, a: 32'd0, d: efv, p: ep, fi: 32'(efi), cyc: t + 1 + pe + ni + RUNC + ce};
      sb.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      if (poke) begin
         n = 0;
         while (!(busy && !cpu_reset && !cpu_stall) && n < 100) begin @(posedge clk); #1; n++; end
         check("reach_run", 32'(busy && !cpu_reset && !cpu_stall), 32'd1);
         start = 1'b1; prog_len = LW'(5); init_len = LW'(3); chk_len = LW'(1);
         @(posedge clk); #1;
         start = 1'b0;
      end
      n = 0;
      while (!done && n < 300) begin @(posedge clk); #1; n++; end
      check("done_seen", 32'(done), 32'd1);
      @(negedge clk); #1;
      check("sb_drained", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      int n;
      for (int k = 0; k < MAXE; k++) begin
         prog[k] = '0; ireg[k] = '0; ival[k] = '0; creg[k] = '0; cval[k] = '0;
      end
      for (int k = 0; k < 32; k++) rf[k] = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_pass", 32'(pass), 32'd0);
      check("rst_we", 32'({imem_we, dbg_we, cpu_stall}), 32'd0);
      check("rst_tbl", 32'({tbl_sel, tbl_idx}), 32'd0);
      check("rst_fail", 32'(fail_idx) | fail_value, 32'd0);
      reset = 1'b0;

      // Add/sub program: done at T+1+2+2+12+2, pass
      set_add_sub();
      run_seq(2, 2, 2, 1'b1, 0, 32'd0, 2, 1'b0);

      // Wrong expectation on r1, started from DONE
      cval[1] = 32'hFFFFFFFA;
      run_seq(2, 2, 2, 1'b0, 1, 32'hFFFFFFFB, 2, 1'b0);

      // Start pulsed during RUN with different lengths is ignored
      cval[1] = 32'hFFFFFFFB;
      run_seq(2, 2, 2, 1'b1, 0, 32'd0, 2, 1'b1);

      // All lengths zero
      run_seq(0, 0, 0, 1'b1, 0, 32'd0, 0, 1'b0);

      // Program length saturation
      for (int k = 0; k < MAXE; k++) prog[k] = 32'hC0DE0000 + 32'(k);
      run_seq(MAXE + 3, 0, 0, 1'b1, 0, 32'd0, 0, 1'b0);

      // Mismatch on the first compare stops after one check
      set_add_sub();
      cval[0] = 32'd21;
      run_seq(2, 2, 2, 1'b0, 0, 32'd20, 1, 1'b0);
      cval[0] = 32'd20;

      // Reset during the second INIT write
      push_writes(2, 1);
      @(posedge clk); #1;
      prog_len = LW'(2); init_len = LW'(2); chk_len = LW'(2);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (!(busy && tbl_sel == 2'd1) && n < 50) begin @(posedge clk); #1; n++; end
      check("reach_init", 32'(tbl_sel), 32'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      check("mid_rst_we_masked", 32'(dbg_we), 32'd0);
      @(posedge clk); #1;
      check("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
      check("mid_rst_dbg_we", 32'(dbg_we), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      reset = 1'b0;
      @(negedge clk); #1;
      check("mid_rst_sb_drained", 32'(sb.size()), 32'd0);

      // A fresh sequence after reset completes normally
      run_seq(2, 2, 2, 1'b1, 0, 32'd0, 2, 1'b0);

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required completion within 100000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
